// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and sizing helpers for the MEM-stage store write buffer
package mem_stage_pkg;

    localparam int SB_DEPTH_DEFAULT  = 4;
    localparam int SB_ADDR_W_DEFAULT = 64;
    localparam int SB_DATA_W_DEFAULT = 64;

    // One buffered store; fields sized for the widest supported address/data (64 bits).
    typedef struct packed {
        logic [SB_ADDR_W_DEFAULT-1:0] addr;
        logic [SB_DATA_W_DEFAULT-1:0] data;
    } sb_entry_t;

    // Pointer width for a power-of-two buffer; never narrower than one bit.
    function automatic int sb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-first load address match against buffered stores
module sb_fwd_match
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = SB_ADDR_W_DEFAULT,
    parameter int PTR_W  = sb_ptr_w(SB_DEPTH_DEFAULT)
) (
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] ent_addr [DEPTH],
    input  logic [DEPTH-1:0]  ent_valid,
    input  logic [PTR_W-1:0]  tail,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx
);

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store FIFO with load forwarding and DATA_MEM port arbitration; optional STORE_COALESCE_EN
module store_write_buffer
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = SB_ADDR_W_DEFAULT,
    parameter int DATA_W = SB_DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ST_VALID,
    input  logic [ADDR_W-1:0] ST_ADDR,
    input  logic [DATA_W-1:0] ST_DATA,
    output logic              ST_READY,
    input  logic              LD_VALID,
    input  logic [ADDR_W-1:0] LD_ADDR,
    output logic [DATA_W-1:0] LD_DATA,
    output logic              LD_FWD,
    input  logic              FLUSH,
    output logic              EMPTY,
    output logic              MEM_WRITE,
    output logic              MEM_READ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int PTR_W = sb_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    sb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              fwd_hit;
    logic [PTR_W-1:0]  fwd_idx;
    logic              full;
    logic              ld_miss;
    logic              drain;
    logic              coalesce;
    logic              accept;
    logic              alloc;
    logic [PTR_W-1:0]  wr_idx;

    // Present the stored addresses at the configured width to the matcher.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = entries[i].addr[ADDR_W-1:0];
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_fwd_match (
        .ld_addr   (LD_ADDR),
        .ent_addr  (ent_addr),
        .ent_valid (ent_valid),
        .tail      (tail),
        .hit       (fwd_hit),
        .hit_idx   (fwd_idx)
    );

    // Full is judged on the registered count, so a same-cycle drain never frees a slot early.
    assign full    = (count == FULL_COUNT);
    assign ld_miss = LD_VALID & ~fwd_hit;
    assign drain   = ~RESET & (count != '0) & ~ld_miss;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] young;
    assign young    = tail - PTR_W'(1);
    // Merge into the youngest entry unless that entry is leaving through the port this cycle.
    assign coalesce = (count != '0) & ent_valid[young]
                    & (entries[young].addr[ADDR_W-1:0] == ST_ADDR)
                    & ~(drain & (young == head));
    assign wr_idx   = coalesce ? young : tail;
`else
    assign coalesce = 1'b0;
    assign wr_idx   = tail;
`endif

    assign ST_READY = ~RESET & ~FLUSH & (~full | coalesce);
    assign accept   = ST_VALID & ST_READY;
    assign alloc    = accept & ~coalesce;

    // FIFO state: drain retires HEAD, accept writes TAIL (or the merged youngest slot).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (accept) begin
                entries[wr_idx].addr <= SB_ADDR_W_DEFAULT'(ST_ADDR);
                entries[wr_idx].data <= SB_DATA_W_DEFAULT'(ST_DATA);
                ent_valid[wr_idx]    <= 1'b1;
            end
            if (alloc) begin
                tail <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(drain);
        end
    end

    // Port mux: a missing load owns the address port; otherwise the head store drains.
    always_comb begin
        LD_DATA   = '0;
        LD_FWD    = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_READ  = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        EMPTY     = 1'b1;
        if (!RESET) begin
            EMPTY = (count == '0);
            if (LD_VALID && fwd_hit) begin
                LD_FWD  = 1'b1;
                LD_DATA = entries[fwd_idx].data[DATA_W-1:0];
            end else if (LD_VALID) begin
                MEM_READ = 1'b1;
                MEM_ADDR = LD_ADDR;
                LD_DATA  = MEM_RDATA;
            end
            if (drain) begin
                MEM_WRITE = 1'b1;
                MEM_ADDR  = entries[head].addr[ADDR_W-1:0];
                MEM_WDATA = entries[head].data[DATA_W-1:0];
            end
        end
    end

endmodule
